ct_loader: RTL and testbench

Front-end stage that receives a length-prefixed ciphertext byte stream over a valid/ready handshake and writes it into the ciphertext memory: the length goes at address 0, payload byte i at address i. When the load completes it hands the memory port to the `crack` engine, pulses its start, and waits for the search to finish. It then latches the key result for the board-level display logic.

---
 rtl/crack_pkg.sv | 16 +
 rtl/ct_loader_ld_counter.sv | 34 +++
 rtl/ct_loader.sv | 98 +++++++++
 tb/tb_ct_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and constants for the ciphertext loader and its key-search handshake.
package crack_pkg;

  localparam int KEY_W    = 24;
  localparam int ADDR_W   = 8;
  localparam int LEN_ADDR = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } ld_state_t;

endpackage

// File: rtl/ct_loader_ld_counter.sv
// Payload write pointer: loads 1 when the length byte is accepted, steps once per
// payload byte, and flags the final byte (wptr == L) so it never wraps past the length.
module ld_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_inc,
  input  logic [W-1:0] i_len,
  output logic [W-1:0] o_wptr,
  output logic         o_last
);

  logic [W-1:0] r_wptr;
  logic [W-1:0] r_len;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_len  <= '0;
    end else if (i_load) begin
      r_wptr <= W'(1);
      r_len  <= i_len;
    end else if (i_inc && !o_last) begin
      r_wptr <= r_wptr + W'(1);
    end
  end

  assign o_wptr = r_wptr;
  assign o_last = (r_wptr == r_len);

endmodule

// File: rtl/ct_loader.sv
// Loads a length-prefixed ciphertext stream into memory, then hands the memory port
// to the crack engine, pulses its start and latches the reported key.
module ct_loader
  import crack_pkg::*;
#(
  parameter int ADDR_W = crack_pkg::ADDR_W,
  parameter int KEY_W  = crack_pkg::KEY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [7:0]        ct_wrdata,
  output logic              ct_wren,
  input  logic [ADDR_W-1:0] crack_ct_addr,
  output logic              crack_en,
  input  logic              crack_rdy,
  input  logic [KEY_W-1:0]  crack_key,
  input  logic              crack_key_valid,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_found,
  output logic              done
);

  ld_state_t         r_state;
  logic              r_seen_low;
  logic [KEY_W-1:0]  r_key;
  logic              r_key_found;
  logic              r_done;

  logic              w_loading;
  logic              w_accept;
  logic [ADDR_W-1:0] w_wptr;
  logic              w_last;

  assign w_loading = (r_state == IDLE) || (r_state == LOAD);
  assign w_accept  = in_valid && w_loading;

  ld_counter #(.W(ADDR_W)) u_ld_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load ((r_state == IDLE) && w_accept),
    .i_inc  ((r_state == LOAD) && w_accept),
    .i_len  (ADDR_W'(in_data)),
    .o_wptr (w_wptr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_seen_low  <= 1'b0;
      r_key       <= '0;
      r_key_found <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE:  if (w_accept) r_state <= (in_data == 8'd0) ? START : LOAD;
        LOAD:  if (w_accept && w_last) r_state <= START;
        START: if (crack_rdy) begin
          r_state    <= RUN;
          r_seen_low <= 1'b0;
        end
        // The search is finished only after crack_rdy drops and comes back up.
        RUN: begin
          if (!crack_rdy) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_key       <= crack_key;
            r_key_found <= crack_key_valid;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_loading;
  assign ct_wren   = w_accept;
  assign ct_wrdata = w_accept ? in_data : 8'd0;
  assign crack_en  = (r_state == START) && crack_rdy;

  always_comb begin
    ct_addr = crack_ct_addr;
    if (r_state == IDLE)      ct_addr = ADDR_W'(LEN_ADDR);
    else if (r_state == LOAD) ct_addr = w_wptr;
  end

  assign key_out   = r_key;
  assign key_found = r_key_found;
  assign done      = r_done;

endmodule

// File: tb/tb_ct_loader.sv
// Self-checking bench for ct_loader: randomized streams compared against an
// address/data write list derived from the stream format, plus the crack handshake.
module tb_ct_loader;

  localparam int AW = 8;
  localparam int KW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] ct_addr;
  logic [7:0]    ct_wrdata;
  logic          ct_wren;
  logic [AW-1:0] crack_ct_addr;
  logic          crack_en;
  logic          crack_rdy;
  logic [KW-1:0] crack_key;
  logic          crack_key_valid;
  logic [KW-1:0] key_out;
  logic          key_found;
  logic          done;

  ct_loader #(.ADDR_W(AW), .KEY_W(KW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .ct_addr         (ct_addr),
    .ct_wrdata       (ct_wrdata),
    .ct_wren         (ct_wren),
    .crack_ct_addr   (crack_ct_addr),
    .crack_en        (crack_en),
    .crack_rdy       (crack_rdy),
    .crack_key       (crack_key),
    .crack_key_valid (crack_key_valid),
    .key_out         (key_out),
    .key_found       (key_found),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  en_count = 0;
  wr_t obs_q[$];

  // Observed memory writes and start pulses, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && ct_wren) obs_q.push_back('{int'(ct_addr), int'(ct_wrdata), cyc});
    if (rst_n && crack_en) en_count++;
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_q.delete();
    en_count = 0;
  endtask

  // Streams L then the payload; the model is simply "byte k of the stream lands at address k".
  task automatic send_stream(input logic [7:0] pl[$], input int stall_at, input int stall_len,
                             input bit rand_stall);
    logic [7:0] bytes[$];
    wr_t        exp_q[$];
    int         n;
    bytes = pl;
    bytes.push_front(8'(pl.size()));
    for (int idx = 0; idx < bytes.size(); idx++) begin
      n = (idx == stall_at) ? stall_len : 0;
      if (rand_stall && $urandom_range(0, 3) == 0) n += $urandom_range(1, 3);
      in_valid = 1'b0;
      for (int s = 0; s < n; s++) begin
        in_data = 8'($urandom_range(0, 255));
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || ct_wren !== 1'b0) begin
          errors++;
          $display("FAIL stall idx=%0d: in_ready=%b ct_wren=%b, expected 1 0", idx, in_ready, ct_wren);
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = bytes[idx];
      @(negedge clk);
      checks++;
      if (ct_wren !== 1'b1 || in_ready !== 1'b1 || ct_addr !== AW'(idx) || ct_wrdata !== bytes[idx]) begin
        errors++;
        $display("FAIL write idx=%0d: wren=%b rdy=%b addr=%0h data=%0h, expected 1 1 %0h %0h",
                 idx, ct_wren, in_ready, ct_addr, ct_wrdata, idx, bytes[idx]);
      end
      exp_q.push_back('{idx, int'(bytes[idx]), 0});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) begin
        errors++;
        $display("FAIL write_log[%0d]: got (%0h,%0h) expected (%0h,%0h)", i,
                 obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (en_count != 0) begin
      errors++;
      $display("FAIL early_start: crack_en pulses=%0d expected 0", en_count);
    end
  endtask

  // Called right after the last accept, i.e. in the first START cycle.
  task automatic start_handshake(input int low_cycles);
    if (low_cycles > 0) crack_rdy = 1'b0;
    for (int s = 0; s < low_cycles; s++) begin
      @(negedge clk);
      checks++;
      if (crack_en !== 1'b0 || in_ready !== 1'b0 || ct_wren !== 1'b0) begin
        errors++;
        $display("FAIL start_wait s=%0d: en=%b rdy=%b wren=%b expected 0 0 0", s, crack_en, in_ready, ct_wren);
      end
      @(posedge clk); #1;
    end
    crack_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (crack_en !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: crack_en=%b in_ready=%b expected 1 0", crack_en, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (crack_en !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: crack_en=%b expected 0", crack_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic finish_run(input logic [KW-1:0] key, input bit kv, input int high_cycles,
                            input int low_cycles);
    for (int s = 0; s < high_cycles; s++) begin
      crack_key = KW'($urandom);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || crack_en !== 1'b0) begin
        errors++;
        $display("FAIL run_high s=%0d: done=%b crack_en=%b expected 0 0", s, done, crack_en);
      end
      @(posedge clk); #1;
    end
    crack_rdy = 1'b0;
    for (int s = 0; s < low_cycles; s++) begin
      crack_ct_addr = AW'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ct_addr !== crack_ct_addr || ct_wren !== 1'b0) begin
        errors++;
        $display("FAIL run_low s=%0d: done=%b addr=%0h wren=%b expected 0 %0h 0", s, done, ct_addr,
                 ct_wren, crack_ct_addr);
      end
      @(posedge clk); #1;
    end
    crack_rdy       = 1'b1;
    crack_key       = key;
    crack_key_valid = kv;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_early: done=%b expected 0", done);
    end
    @(posedge clk); #1;
    crack_key       = ~key;
    crack_key_valid = ~kv;
    crack_rdy       = 1'b0;
    @(negedge clk);
    checks++;
    if (key_out !== key || key_found !== kv || done !== 1'b1 || en_count != 1) begin
      errors++;
      $display("FAIL result: key=%0h found=%b done=%b pulses=%0d expected %0h %b 1 1",
               key_out, key_found, done, en_count, key, kv);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 8'h00; crack_rdy = 1'b0;
    crack_key = '0; crack_key_valid = 1'b0; crack_ct_addr = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, ct_wren, crack_en, key_out, key_found, done, ct_addr} !==
        {1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b wren=%b en=%b key=%0h found=%b done=%b addr=%0h",
               in_ready, ct_wren, crack_en, key_out, key_found, done, ct_addr);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, ct_wren, crack_en, done, ct_addr} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b wren=%b en=%b done=%b addr=%0h expected 1 0 0 0 0",
               in_ready, ct_wren, crack_en, done, ct_addr);
    end
  endtask

  task automatic test_normal();
    logic [7:0] pl[$];
    pl = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    crack_rdy = 1'b1;
    send_stream(pl, -1, 0, 1'b0);
    checks++;
    if (obs_q.size() != 4 || obs_q[3].cyc != obs_q[0].cyc + 3) begin
      errors++;
      $display("FAIL consecutive: writes=%0d span=%0d expected 4 3", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1].cyc - obs_q[0].cyc : -1);
    end
    start_handshake(0);
    finish_run(KW'($urandom), 1'b1, 2, 1);
  endtask

  task automatic test_stall();
    logic [7:0] pl[$];
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom_range(0, 255)));
    do_reset();
    crack_rdy = 1'b1;
    send_stream(pl, 4, 5, 1'b0);
    start_handshake(0);
    finish_run(KW'($urandom), 1'b0, 0, 2);
  endtask

  task automatic test_random();
    logic [7:0] pl[$];
    for (int t = 0; t < 4; t++) begin
      pl.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) pl.push_back(8'($urandom_range(0, 255)));
      do_reset();
      crack_rdy = 1'($urandom_range(0, 1));
      send_stream(pl, -1, 0, 1'b1);
      start_handshake(int'($urandom_range(0, 4)));
      finish_run(KW'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] pl[$];
    do_reset();
    crack_rdy = 1'b1;
    send_stream(pl, -1, 0, 1'b0);
    start_handshake(0);
    finish_run(KW'($urandom), 1'b1, 1, 1);
  endtask

  task automatic test_max_len();
    logic [7:0] pl[$];
    for (int i = 0; i < 255; i++) pl.push_back(8'($urandom_range(0, 255)));
    do_reset();
    crack_rdy = 1'b0;
    send_stream(pl, -1, 0, 1'b0);
    start_handshake(1);
    finish_run(KW'($urandom), 1'b1, 0, 1);
  endtask

  task automatic test_handshake_and_done();
    logic [7:0] pl[$];
    int         n_writes;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    crack_rdy = 1'b0;
    send_stream(pl, -1, 0, 1'b0);
    start_handshake(10);
    finish_run(24'h1E4600, 1'b1, 3, 4);
    n_writes = obs_q.size();
    for (int s = 0; s < 8; s++) begin
      in_valid      = 1'b1;
      in_data       = 8'($urandom_range(0, 255));
      crack_rdy     = 1'($urandom_range(0, 1));
      crack_ct_addr = AW'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || ct_wren !== 1'b0 || done !== 1'b1 || key_out !== 24'h1E4600 ||
          key_found !== 1'b1 || crack_en !== 1'b0 || ct_addr !== crack_ct_addr) begin
        errors++;
        $display("FAIL after_done s=%0d: rdy=%b wren=%b done=%b key=%0h found=%b en=%b addr=%0h",
                 s, in_ready, ct_wren, done, key_out, key_found, crack_en, ct_addr);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (obs_q.size() != n_writes) begin
      errors++;
      $display("FAIL done_writes: got %0d writes expected %0d", obs_q.size(), n_writes);
    end
    crack_rdy = 1'b0;
    rst_n     = 1'b0;
    #2;
    checks++;
    if ({in_ready, ct_wren, crack_en, key_out, key_found, done, ct_addr} !==
        {1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_clears: rdy=%b wren=%b en=%b key=%0h found=%b done=%b addr=%0h",
               in_ready, ct_wren, crack_en, key_out, key_found, done, ct_addr);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] part[$];
    logic [7:0] pl[$];
    part = '{8'h05, 8'h9C, 8'h3D};
    do_reset();
    crack_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = part[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({in_ready, ct_wren, crack_en, key_out, key_found, done, ct_addr} !==
        {1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset_mid_load: rdy=%b wren=%b en=%b key=%0h found=%b done=%b addr=%0h",
               in_ready, ct_wren, crack_en, key_out, key_found, done, ct_addr);
    end
    for (int i = 0; i < 7; i++) pl.push_back(8'($urandom_range(0, 255)));
    do_reset();
    send_stream(pl, -1, 0, 1'b1);
    start_handshake(2);
    finish_run(KW'($urandom), 1'b1, 1, 2);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_zero_len();
    test_max_len();
    test_random();
    test_handshake_and_done();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
